// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer.
// State encoding of the release FSM.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD,
    GAP,
    IDLE,
    EMPTY
  } seq_state_e;

endpackage

// File: rtl/rst_seq_ff1.sv
// Find-first-set over an N-bit vector.
// Lowest set index plus an all-zero flag.
module rst_seq_ff1 #(
  parameter int N    = 4,
  parameter int IdxW = 2
) (
  input  logic [N-1:0]    vec_i,
  output logic [IdxW-1:0] idx_o,
  output logic            empty_o
);

  always_comb begin
    idx_o   = '0;
    empty_o = ~|vec_i;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IdxW'(i);
    end
  end

endmodule

// File: rtl/rst_seq_gen.sv
// Multi-channel reset sequencer: staged release of
// NumRst active-low resets, with runtime re-reset requests.
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int NumRst     = 4,
  parameter int HoldCycles = 8,
  parameter int GapCycles  = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [NumRst-1:0] req_mask_i,
  output logic [NumRst-1:0] rst_no,
  output logic              busy_o,
  output logic              done_o
);

  localparam int MaxCyc =
    (HoldCycles > GapCycles) ? HoldCycles : GapCycles;
  localparam int CntWidth = $clog2(MaxCyc + 1);
  localparam int IdxW = (NumRst > 1) ? $clog2(NumRst) : 1;

  initial begin
    if (NumRst < 1) $fatal(1, "NumRst must be >= 1");
    if (HoldCycles < 1) $fatal(1, "HoldCycles must be >= 1");
    if (GapCycles < 1) $fatal(1, "GapCycles must be >= 1");
  end

  seq_state_e state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [NumRst-1:0]   mask_q, mask_d;
  logic [NumRst-1:0]   rst_q, rst_d;
  logic                done_q, done_d;

  logic [NumRst-1:0]   ff1_vec;
  logic [IdxW-1:0]     ff1_idx;
  logic                ff1_empty;
  logic [NumRst-1:0]   mask_left;
  logic [CntWidth-1:0] lim;

  // In IDLE the finder tests the request mask; otherwise it
  // picks the next channel to release from the active mask.
  assign ff1_vec = (state_q == IDLE) ? req_mask_i : mask_q;

  rst_seq_ff1 #(
    .N    (NumRst),
    .IdxW (IdxW)
  ) u_ff1 (
    .vec_i   (ff1_vec),
    .idx_o   (ff1_idx),
    .empty_o (ff1_empty)
  );

  assign mask_left = mask_q & ~(NumRst'(1) << ff1_idx);
  assign lim = (state_q == GAP) ? CntWidth'(GapCycles - 1)
                                : CntWidth'(HoldCycles - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    rst_d   = rst_q;
    done_d  = 1'b0;
    unique case (state_q)
      HOLD, GAP: begin
        if (cnt_q == lim) begin
          rst_d[ff1_idx] = 1'b1;
          mask_d = mask_left;
          cnt_d  = '0;
          if (~|mask_left) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      IDLE: begin
        if (req_valid_i) begin
          if (ff1_empty) begin
            state_d = EMPTY;
            done_d  = 1'b1;
          end else begin
            mask_d  = req_mask_i;
            rst_d   = rst_q & ~req_mask_i;
            cnt_d   = '0;
            state_d = HOLD;
          end
        end
      end
      EMPTY: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      mask_q  <= '1;
      rst_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = ~req_ready_o;
  assign rst_no      = rst_q;
  assign done_o      = done_q;

endmodule
